// File: rtl/vga_pkg.sv
// Shared timing defaults, phase encodings and the per-pixel control bundle
// for the VGA scan path.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FRONT_DEF  = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BACK_DEF   = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FRONT_DEF  = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BACK_DEF   = 33;

  // Largest line/frame length the 11-bit counters can hold.
  localparam int unsigned MAX_TOTAL      = 2047;
  localparam int unsigned MAX_PIPE_DELAY = 7;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  typedef enum logic [1:0] {HAct, HFp, HSy, HBp} h_phase_t;
  typedef enum logic [1:0] {VAct, VFp, VSy, VBp} v_phase_t;

  // Raw (active-high) per-pixel control; polarity is applied at the pins.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } scan_ctrl_t;

  localparam scan_ctrl_t SCAN_CTRL_IDLE = '{hsync: 1'b0, vsync: 1'b0, active: 1'b0};

  // RGB332 to 4:4:4 by replicating the top bits of each channel.
  function automatic logic [11:0] expand_rgb332(input logic [7:0] c);
    return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
  endfunction

endpackage

// File: rtl/vga_scan_controller_if.sv
// Raster bus between the scan controller, the object drawers and the DAC pins.
interface vga_scan_controller_if;
  logic [7:0]  RGBin;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        hsync;
  logic        vsync;
  logic        blankN;
  logic [3:0]  redOut;
  logic [3:0]  greenOut;
  logic [3:0]  blueOut;

  modport master (
    input  RGBin,
    output pixelX, pixelY, startOfFrame, hsync, vsync, blankN, redOut, greenOut, blueOut
  );

  modport slave (
    output RGBin,
    input  pixelX, pixelY, startOfFrame, hsync, vsync, blankN, redOut, greenOut, blueOut
  );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that delays per-pixel control to match the
// object pipeline. Depth 0 degenerates to wires.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  scan_ctrl_t ctrl_i,
  output scan_ctrl_t ctrl_o
);

  if (Depth > MAX_PIPE_DELAY) begin : g_bad_depth
    $error("vga_delay_line: Depth must be 0..7");
  end

  if (Depth == 0) begin : g_wire
    assign ctrl_o = ctrl_i;
  end else begin : g_shift
    scan_ctrl_t stage_q [Depth];
    scan_ctrl_t stage_d [Depth];

    // Shift one stage per pixel clock.
    always_comb begin
      stage_d[0] = ctrl_i;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Reset flushes every stage to blank with sync inactive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(Depth); i++) begin
          stage_q[i] <= SCAN_CTRL_IDLE;
        end
      end else begin
        for (int i = 0; i < int'(Depth); i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign ctrl_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster master: issues pixelX/pixelY, decodes sync/active from two phase
// FSMs, delays that control to meet the returning RGBin and drives the pins.
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE         = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT          = H_FRONT_DEF,
  parameter int unsigned H_SYNC           = H_SYNC_DEF,
  parameter int unsigned H_BACK           = H_BACK_DEF,
  parameter int unsigned V_ACTIVE         = V_ACTIVE_DEF,
  parameter int unsigned V_FRONT          = V_FRONT_DEF,
  parameter int unsigned V_SYNC           = V_SYNC_DEF,
  parameter int unsigned V_BACK           = V_BACK_DEF,
  parameter bit          SYNC_ACTIVE_LOW  = 1'b1,
  parameter int unsigned PIPE_DELAY       = 1,
  parameter logic [7:0]  BACKGROUND_COLOR = 8'h00
) (
  input  logic                   clk,
  input  logic                   resetN,
  vga_scan_controller_if.master  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > MAX_TOTAL) begin : g_bad_h_total
    $error("vga_scan_controller: H_TOTAL exceeds 2047");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_bad_v_total
    $error("vga_scan_controller: V_TOTAL exceeds 2047");
  end
  if (PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_pipe
    $error("vga_scan_controller: PIPE_DELAY must be 0..7");
  end

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FP_START = 11'(H_ACTIVE);
  localparam logic [10:0] H_SY_START = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_BP_START = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_FP_START = 11'(V_ACTIVE);
  localparam logic [10:0] V_SY_START = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_BP_START = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic        SYNC_IDLE  = SYNC_ACTIVE_LOW;

  // hcount/vcount hold the coordinate to be issued on the next clock;
  // pixel_x/y and the phase registers describe the coordinate on the bus now.
  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic [10:0] pixel_x_q, pixel_y_q;
  h_phase_t    h_phase_q, h_phase_d;
  v_phase_t    v_phase_q, v_phase_d;
  logic        sof_q, sof_d;
  logic        line_start;

  scan_ctrl_t  ctrl_raw, ctrl_dly;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_n_q, blank_n_d;
  logic [11:0] rgb_q, rgb_d;
  logic [7:0]  pix_color;

  // Raster counters and phase FSM next-state.
  always_comb begin
    hcount_d  = (hcount_q == H_LAST) ? '0 : hcount_q + 11'd1;
    vcount_d  = vcount_q;
    if (hcount_q == H_LAST) begin
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 11'd1;
    end

    h_phase_d = h_phase_q;
    case (h_phase_q)
      HAct:    if (hcount_q == H_FP_START) h_phase_d = HFp;
      HFp:     if (hcount_q == H_SY_START) h_phase_d = HSy;
      HSy:     if (hcount_q == H_BP_START) h_phase_d = HBp;
      HBp:     if (hcount_q == '0)         h_phase_d = HAct;
      default: h_phase_d = HBp;
    endcase

    // A new line is about to be issued exactly when hcount has wrapped to 0.
    line_start = (hcount_q == '0);
    v_phase_d  = v_phase_q;
    if (line_start) begin
      case (v_phase_q)
        VAct:    if (vcount_q == V_FP_START) v_phase_d = VFp;
        VFp:     if (vcount_q == V_SY_START) v_phase_d = VSy;
        VSy:     if (vcount_q == V_BP_START) v_phase_d = VBp;
        VBp:     if (vcount_q == '0)         v_phase_d = VAct;
        default: v_phase_d = VAct;
      endcase
    end

    sof_d = (v_phase_q == VAct) && (v_phase_d == VFp);
  end

  // Scan state; the reset pixel is held in back porch so no phantom pixel or
  // partial sync is emitted before (0,0).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hcount_q  <= '0;
      vcount_q  <= '0;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      h_phase_q <= HBp;
      v_phase_q <= VAct;
      sof_q     <= 1'b0;
    end else begin
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      pixel_x_q <= hcount_q;
      pixel_y_q <= vcount_q;
      h_phase_q <= h_phase_d;
      v_phase_q <= v_phase_d;
      sof_q     <= sof_d;
    end
  end

  // Per-pixel control decoded purely from the phase FSMs.
  always_comb begin
    ctrl_raw        = SCAN_CTRL_IDLE;
    ctrl_raw.hsync  = (h_phase_q == HSy);
    ctrl_raw.vsync  = (v_phase_q == VSy);
    ctrl_raw.active = (h_phase_q == HAct) && (v_phase_q == VAct);
  end

  vga_delay_line #(
    .Depth (PIPE_DELAY)
  ) u_delay_line (
    .clk_i  (clk),
    .rst_ni (resetN),
    .ctrl_i (ctrl_raw),
    .ctrl_o (ctrl_dly)
  );

  // Pin values: polarity, blanking and transparent-to-background substitution.
  always_comb begin
    hsync_d   = SYNC_ACTIVE_LOW ? ~ctrl_dly.hsync : ctrl_dly.hsync;
    vsync_d   = SYNC_ACTIVE_LOW ? ~ctrl_dly.vsync : ctrl_dly.vsync;
    blank_n_d = ctrl_dly.active;
    pix_color = (bus.RGBin == TRANSPARENT_ENCODING) ? BACKGROUND_COLOR : bus.RGBin;
    rgb_d     = ctrl_dly.active ? expand_rgb332(pix_color) : '0;
  end

  // Output register driving the monitor pins.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hsync_q   <= SYNC_IDLE;
      vsync_q   <= SYNC_IDLE;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign bus.pixelX       = pixel_x_q;
  assign bus.pixelY       = pixel_y_q;
  assign bus.startOfFrame = sof_q;
  assign bus.hsync        = hsync_q;
  assign bus.vsync        = vsync_q;
  assign bus.blankN       = blank_n_q;
  assign bus.redOut       = rgb_q[11:8];
  assign bus.greenOut     = rgb_q[7:4];
  assign bus.blueOut      = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboarded bench for vga_scan_controller: default horizontal timing, a
// short vertical frame so whole frames fit in the run, random RGBin.
module tb_vga_scan_controller;
  import vga_pkg::*;

  localparam int unsigned HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int unsigned VA = 20, VF = 10, VS = 2, VB = 3;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned PD = 1;
  localparam logic [7:0]  BG = 8'h1C;

  typedef struct packed {
    logic [10:0] px;
    logic [10:0] py;
    logic        sof;
    logic        hs;
    logic        vs;
    logic        bn;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
  } obs_t;

  localparam obs_t IDLE = '{px: 11'd0, py: 11'd0, sof: 1'b0, hs: 1'b1, vs: 1'b1, bn: 1'b0,
                            r: 4'd0, g: 4'd0, b: 4'd0};

  logic clk    = 1'b0;
  logic resetN = 1'b1;

  vga_scan_controller_if bus();

  vga_scan_controller #(
    .H_ACTIVE         (HA),
    .H_FRONT          (HF),
    .H_SYNC           (HS),
    .H_BACK           (HB),
    .V_ACTIVE         (VA),
    .V_FRONT          (VF),
    .V_SYNC           (VS),
    .V_BACK           (VB),
    .SYNC_ACTIVE_LOW  (1'b1),
    .PIPE_DELAY       (PD),
    .BACKGROUND_COLOR (BG)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   sof_seen = 0;
  int   sof_exp  = 0;

  // Expected bus/pins after the (m+1)-th clock since reset release, given the
  // RGBin presented to that clock. Pixel index m is on pixelX/Y; the pins show
  // index m-PD-1, or idle before any real pixel has reached them.
  function automatic obs_t model(input int unsigned m, input logic [7:0] rgb);
    obs_t        o;
    int unsigned x, y, k;
    logic [7:0]  c;
    o   = IDLE;
    x   = m % HT;
    y   = (m / HT) % VT;
    o.px  = 11'(x);
    o.py  = 11'(y);
    o.sof = (x == 0) && (y == VA);
    if (m >= PD + 1) begin
      k    = m - PD - 1;
      x    = k % HT;
      y    = (k / HT) % VT;
      o.hs = !(x >= HA + HF && x < HA + HF + HS);
      o.vs = !(y >= VA + VF && y < VA + VF + VS);
      if (x < HA && y < VA) begin
        c    = (rgb == 8'hFF) ? BG : rgb;
        o.bn = 1'b1;
        o.r  = {c[7:5], c[7]};
        o.g  = {c[4:2], c[4]};
        o.b  = {c[1:0], c[1:0]};
      end
    end
    return o;
  endfunction

  function automatic obs_t sample();
    return {bus.pixelX, bus.pixelY, bus.startOfFrame, bus.hsync, bus.vsync, bus.blankN,
            bus.redOut, bus.greenOut, bus.blueOut};
  endfunction

  task automatic report(input string tag, input obs_t a, input obs_t e);
    $display("FAIL %s: got px=%0d py=%0d sof=%b hs=%b vs=%b bn=%b rgb=%h/%h/%h ; need px=%0d py=%0d sof=%b hs=%b vs=%b bn=%b rgb=%h/%h/%h",
             tag, a.px, a.py, a.sof, a.hs, a.vs, a.bn, a.r, a.g, a.b,
             e.px, e.py, e.sof, e.hs, e.vs, e.bn, e.r, e.g, e.b);
  endtask

  // Monitor: the DUT presents a new pixel every clock; compare mid-cycle.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample();
      n_cmp++;
      if (a.sof) sof_seen++;
      if (a !== e) begin
        n_bad++;
        report("scan", a, e);
      end
    end
  end

  task automatic check_idle(input string tag);
    obs_t a;
    a = sample();
    n_cmp++;
    if (a !== IDLE) begin
      n_bad++;
      report(tag, a, IDLE);
    end
  endtask

  // Asynchronous reset asserted mid-cycle, held a few clocks, released mid-cycle.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #1 resetN = 1'b0;
    #1 check_idle({tag, "_async"});
    repeat (3) @(negedge clk);
    check_idle({tag, "_held"});
    #1 resetN = 1'b1;
  endtask

  // Stimulus: drive RGBin for the next clock and push what that clock must show.
  task automatic run(input int unsigned cycles);
    logic [7:0] rgb;
    obs_t       e;
    for (int unsigned m = 0; m < cycles; m++) begin
      case ($urandom_range(0, 7))
        0:       rgb = 8'hFF;
        1:       rgb = 8'hE0;
        default: rgb = 8'($urandom);
      endcase
      bus.RGBin = rgb;
      e = model(m, rgb);
      if (e.sof) sof_exp++;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.RGBin = 8'h00;
    pulse_reset("reset_init");
    run(301);                       // ends with pixelX=300 on line 0
    pulse_reset("reset_mid_active");
    run(1501);                      // ends with pixelX=700 (inside hsync) on line 1
    pulse_reset("reset_mid_hsync");
    run(2 * HT * VT + 500);         // two full frames plus a little
    @(negedge clk);
    #1;
    n_cmp++;
    if (sof_seen != sof_exp || sof_exp != 2) begin
      n_bad++;
      $display("FAIL sof_count: got %0d pulses, need %0d (model) and 2", sof_seen, sof_exp);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
